// File: rtl/bcd_disp_mux.sv
// Four-digit multiplexed BCD display driver. New data is queued in a pending
// register and swapped into the display only at a frame boundary, so no frame shows mixed data.
module bcd_disp_mux #(
   parameter int N = 18
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] bcd3,
   input  logic [3:0] bcd2,
   input  logic [3:0] bcd1,
   input  logic [3:0] bcd0,
   input  logic [3:0] dp_in,
   input  logic       lz_en,
   input  logic       lamp_test,
   output logic [3:0] an,
   output logic [7:0] sseg,
   output logic       shown_tick
);

   localparam logic [N-1:0] QStep = 1;

   logic [N-1:0]    q_reg;
   logic [1:0]      sel;
   logic            frame_end;
   logic            transfer;
   logic [3:0][3:0] pend_digit_reg;
   logic [3:0][3:0] disp_digit_reg;
   logic [3:0]      pend_dp_reg;
   logic [3:0]      disp_dp_reg;
   logic            pend_flag_reg;
   logic [3:1]      lead_zero;
   logic [3:0]      blank;
   logic [3:0]      digit;
   logic [6:0]      seg7;
   logic [3:0]      an_next;
   logic [7:0]      sseg_next;

   assign sel       = q_reg[N-1:N-2];
   assign frame_end = &q_reg;
   assign transfer  = frame_end & pend_flag_reg;

   // lead_zero[i]: digits 3..i of the displayed value are all zero
   genvar gi;
   generate
      for (gi = 1; gi < 4; gi++) begin : g_blank
         if (gi == 3) begin : g_top
            assign lead_zero[gi] = (disp_digit_reg[gi] == 4'd0);
         end else begin : g_lower
            assign lead_zero[gi] = (disp_digit_reg[gi] == 4'd0) & lead_zero[gi+1];
         end
         assign blank[gi] = lz_en & lead_zero[gi] & ~disp_dp_reg[gi];
      end
   endgenerate
   assign blank[0] = 1'b0;

   always_comb begin
      digit = disp_digit_reg[sel];
      case (digit)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b0111111;
      endcase
      an_next   = ~(4'b0001 << sel);
      sseg_next = {~disp_dp_reg[sel], seg7};
      // Lamp test keeps the scan running but overrides blanking
      if (lamp_test) begin
         sseg_next = 8'h00;
      end else if (blank[sel]) begin
         an_next   = 4'hF;
         sseg_next = 8'hFF;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_reg          <= '0;
         pend_digit_reg <= '0;
         disp_digit_reg <= '0;
         pend_dp_reg    <= '0;
         disp_dp_reg    <= '0;
         pend_flag_reg  <= 1'b0;
         shown_tick     <= 1'b0;
         an             <= 4'hF;
         sseg           <= 8'hFF;
      end else begin
         q_reg      <= q_reg + QStep;
         shown_tick <= transfer;
         an         <= an_next;
         sseg       <= sseg_next;
         if (transfer) begin
            disp_digit_reg <= pend_digit_reg;
            disp_dp_reg    <= pend_dp_reg;
         end
         // A load on the boundary edge re-arms the flag after the old value moves out
         if (load) begin
            pend_digit_reg <= {bcd3, bcd2, bcd1, bcd0};
            pend_dp_reg    <= dp_in;
            pend_flag_reg  <= 1'b1;
         end else if (frame_end) begin
            pend_flag_reg  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Bench for bcd_disp_mux at N=4: spec-constant vector table, hand sequences
// for load/boundary/reset corners, and random stimulus against a frame-level model.
module tb_bcd_disp_mux;

   logic       clk;
   logic       reset;
   logic       load;
   logic [3:0] bcd3, bcd2, bcd1, bcd0;
   logic [3:0] dp_in;
   logic       lz_en;
   logic       lamp_test;
   logic [3:0] an;
   logic [7:0] sseg;
   logic       shown_tick;

   int tests;
   int fails;

   bcd_disp_mux #(.N(4)) dut (
      .clk(clk), .reset(reset), .load(load),
      .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
      .dp_in(dp_in), .lz_en(lz_en), .lamp_test(lamp_test),
      .an(an), .sseg(sseg), .shown_tick(shown_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: cycle count, queued value, shown value
   logic [6:0] seg_lut [16];
   int         m_cnt;
   logic [3:0] m_pend_d [4];
   logic [3:0] m_disp_d [4];
   logic [3:0] m_pend_dp;
   logic [3:0] m_disp_dp;
   bit         m_valid;

   typedef struct {
      logic [3:0][3:0] d;
      logic [3:0]      dp;
      logic            lz;
      logic [3:0][7:0] seg;
      logic [3:0][3:0] an;
   } vec_t;
   vec_t vecs [7];

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic void ref_out(input int s, output logic [3:0] a, output logic [7:0] g);
      bit blk;
      blk = 1'b0;
      if (lz_en && s > 0 && !m_disp_dp[s]) begin
         blk = 1'b1;
         for (int j = s; j < 4; j++) if (m_disp_d[j] != 4'd0) blk = 1'b0;
      end
      a = ~(4'b0001 << s);
      if (lamp_test) g = 8'h00;
      else if (blk) begin
         a = 4'hF;
         g = 8'hFF;
      end else g = {~m_disp_dp[s], seg_lut[m_disp_d[s]]};
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      m_valid = 1'b0;
      m_pend_dp = '0;
      m_disp_dp = '0;
      for (int i = 0; i < 4; i++) begin
         m_pend_d[i] = '0;
         m_disp_d[i] = '0;
      end
   endtask

   // One clock: predict from pre-edge inputs, clock, then compare all outputs
   task automatic tick();
      int s;
      bit bnd, t, ld;
      logic [3:0] a, nd [4], ndp;
      logic [7:0] g;
      s   = (m_cnt % 16) / 4;
      bnd = (m_cnt % 16) == 15;
      ref_out(s, a, g);
      t   = bnd && m_valid;
      ld  = load;
      nd[3] = bcd3; nd[2] = bcd2; nd[1] = bcd1; nd[0] = bcd0;
      ndp = dp_in;
      @(posedge clk);
      if (t) begin
         m_disp_d  = m_pend_d;
         m_disp_dp = m_pend_dp;
      end
      if (ld) begin
         m_pend_d  = nd;
         m_pend_dp = ndp;
         m_valid   = 1'b1;
      end else if (bnd) m_valid = 1'b0;
      m_cnt++;
      #1;
      check("model_an", {4'h0, an}, {4'h0, a});
      check("model_sseg", sseg, g);
      check("model_tick", {7'h0, shown_tick}, {7'h0, t});
   endtask

   task automatic do_reset();
      #2 reset = 1'b0;
      load = 1'b0;
      #1;
      model_reset();
      check("rst_an", {4'h0, an}, 8'h0F);
      check("rst_sseg", sseg, 8'hFF);
      check("rst_tick", {7'h0, shown_tick}, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_an", {4'h0, an}, 8'h0F);
      check("rst_hold_sseg", sseg, 8'hFF);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                             input logic [3:0] d1, input logic [3:0] d0, input logic [3:0] dp);
      bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0; dp_in = dp;
   endtask

   initial begin
      logic [3:0] ea;
      bit seen;
      int pulses;
      tests = 0;
      fails = 0;
      reset = 1'b1; load = 1'b0; lz_en = 1'b0; lamp_test = 1'b0;
      set_digits(0, 0, 0, 0, 0);
      seg_lut[0] = 7'b1000000; seg_lut[1] = 7'b1111001; seg_lut[2] = 7'b0100100;
      seg_lut[3] = 7'b0110000; seg_lut[4] = 7'b0011001; seg_lut[5] = 7'b0010010;
      seg_lut[6] = 7'b0000010; seg_lut[7] = 7'b1111000; seg_lut[8] = 7'b0000000;
      seg_lut[9] = 7'b0010000;
      for (int v = 10; v < 16; v++) seg_lut[v] = 7'b0111111;

      vecs[0] = '{d: {4'd1, 4'd2, 4'd3, 4'd4}, dp: 4'b0000, lz: 1'b0,
                  seg: {8'b11111001, 8'b10100100, 8'b10110000, 8'b10011001},
                  an: {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
      vecs[1] = '{d: {4'd0, 4'd0, 4'd0, 4'd5}, dp: 4'b0010, lz: 1'b1,
                  seg: {8'hFF, 8'hFF, 8'b01000000, 8'b10010010},
                  an: {4'b1111, 4'b1111, 4'b1101, 4'b1110}};
      vecs[2] = '{d: {4'd7, 4'd12, 4'd9, 4'd8}, dp: 4'b1000, lz: 1'b1,
                  seg: {8'b01111000, 8'b10111111, 8'b10010000, 8'b10000000},
                  an: {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
      vecs[3] = '{d: {4'd0, 4'd0, 4'd6, 4'd0}, dp: 4'b0000, lz: 1'b1,
                  seg: {8'hFF, 8'hFF, 8'b10000010, 8'b11000000},
                  an: {4'b1111, 4'b1111, 4'b1101, 4'b1110}};
      vecs[4] = '{d: {4'd0, 4'd0, 4'd0, 4'd0}, dp: 4'b0001, lz: 1'b1,
                  seg: {8'hFF, 8'hFF, 8'hFF, 8'b01000000},
                  an: {4'b1111, 4'b1111, 4'b1111, 4'b1110}};
      vecs[5] = '{d: {4'd0, 4'd14, 4'd0, 4'd3}, dp: 4'b0000, lz: 1'b1,
                  seg: {8'hFF, 8'b10111111, 8'b11000000, 8'b10110000},
                  an: {4'b1111, 4'b1011, 4'b1101, 4'b1110}};
      vecs[6] = '{d: {4'd0, 4'd0, 4'd0, 4'd0}, dp: 4'b0000, lz: 1'b0,
                  seg: {8'hC0, 8'hC0, 8'hC0, 8'hC0},
                  an: {4'b0111, 4'b1011, 4'b1101, 4'b1110}};

      do_reset();

      // Free-run scan after reset, first without and then with blanking
      for (int i = 0; i < 32; i++) begin
         lz_en = (i >= 16);
         tick();
         ea = 4'b1111 ^ (4'b0001 << ((i % 16) / 4));
         if (lz_en && ((i % 16) / 4) != 0) begin
            check("scan_an_blank", {4'h0, an}, 8'h0F);
            check("scan_sseg_blank", sseg, 8'hFF);
         end else begin
            check("scan_an", {4'h0, an}, {4'h0, ea});
            check("scan_sseg", sseg, 8'hC0);
         end
      end
      $display("[TB] free-run scan done");

      // Vector table: load, wait for the swap, then check each slot of one frame
      for (int v = 0; v < 7; v++) begin
         set_digits(vecs[v].d[3], vecs[v].d[2], vecs[v].d[1], vecs[v].d[0], vecs[v].dp);
         lz_en = vecs[v].lz;
         load = 1'b1;
         tick();
         load = 1'b0;
         seen = 1'b0;
         for (int w = 0; w < 40 && !seen; w++) begin
            tick();
            seen = shown_tick;
         end
         check("tbl_tick_seen", {7'h0, seen}, 8'h01);
         for (int i = 0; i < 16; i++) begin
            tick();
            if (i % 4 == 2) begin
               check("tbl_an", {4'h0, an}, {4'h0, vecs[v].an[i / 4]});
               check("tbl_sseg", sseg, vecs[v].seg[i / 4]);
            end
         end
         $display("[TB] vector %0d digits %h dp %b lz %0d checked", v, vecs[v].d, vecs[v].dp, vecs[v].lz);
      end

      // Lamp test across a frame boundary with a load queued
      set_digits(9, 8, 7, 6, 4'b0101);
      load = 1'b1;
      tick();
      load = 1'b0;
      lamp_test = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("lamp_sseg", sseg, 8'h00);
      end
      lamp_test = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      $display("[TB] lamp test sequence done");

      // Load A at edge 3, load B on boundary edge 15
      do_reset();
      lz_en = 1'b0;
      pulses = 0;
      for (int e = 0; e < 48; e++) begin
         load = (e == 3) || (e == 15);
         if (e == 3) set_digits(0, 0, 0, 3, 0);
         if (e == 15) set_digits(0, 0, 0, 7, 0);
         tick();
         load = 1'b0;
         if (shown_tick) pulses++;
         check("ab_tick", {7'h0, shown_tick}, {7'h0, (e == 15) || (e == 31)});
         if (e == 16) check("ab_a_digit0", sseg, 8'b10110000);
         if (e == 32) check("ab_b_digit0", sseg, 8'b11111000);
      end
      check("ab_pulse_count", 8'(pulses), 8'd2);
      $display("[TB] back-to-back load sequence done, %0d pulses", pulses);

      // Reset mid-frame discards a pending load
      do_reset();
      set_digits(1, 1, 1, 1, 4'b1111);
      for (int e = 0; e < 7; e++) begin
         load = (e == 2);
         tick();
      end
      load = 1'b0;
      do_reset();
      for (int e = 0; e < 40; e++) begin
         tick();
         check("discard_tick", {7'h0, shown_tick}, 8'h00);
         check("discard_sseg", sseg, 8'hC0);
      end
      $display("[TB] reset-discard sequence done");

      // Random stimulus against the model
      for (int i = 0; i < 400; i++) begin
         load = ($urandom_range(0, 7) == 0);
         bcd3 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         bcd2 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         bcd1 = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         bcd0 = 4'($urandom_range(0, 15));
         dp_in = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         if (i % 20 == 0) lz_en = 1'($urandom_range(0, 1));
         lamp_test = ($urandom_range(0, 15) == 0);
         if (i == 200) begin
            load = 1'b0;
            do_reset();
         end
         tick();
      end
      load = 1'b0;
      lamp_test = 1'b0;
      $display("[TB] random phase done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
